// File: rtl/fir_add_lane_sched.sv
// fir_add_lane_sched: time-shares one narrow ripple-carry adder lane among
// several FIR tap accumulators. Each WIDTH-bit add is pushed through the
// external lane LANE_W bits at a time, LSB chunk first, with the carry held
// in a flop between chunks. Requesters are served round-robin, one at a time.
module fir_add_lane_sched #(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 12,
  parameter int LANE_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic [LANE_W-1:0]       lane_a,
  output logic [LANE_W-1:0]       lane_b,
  output logic                    lane_cin,
  input  logic [LANE_W-1:0]       lane_s,
  input  logic                    lane_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    busy
);

  localparam int CHUNKS = WIDTH / LANE_W;
  localparam int IDW    = $clog2(NREQ);
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      chunk_q, chunk_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [LANE_W-1:0]  sum_q [CHUNKS];
  logic [LANE_W-1:0]  sum_d [CHUNKS];
  logic               cout_q, cout_d;

  logic [WIDTH-1:0]   req_a_arr [NREQ];
  logic [WIDTH-1:0]   req_b_arr [NREQ];
  logic [LANE_W-1:0]  a_chunks [CHUNKS];
  logic [LANE_W-1:0]  b_chunks [CHUNKS];
  logic [WIDTH-1:0]   sum_flat;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [IDW:0]       scan_idx;
  logic [IDW-1:0]     next_ptr;

  logic               in_idle;
  logic               in_exec;
  logic               in_done;

  assign in_idle = (state_q == IDLE);
  assign in_exec = (state_q == EXEC);
  assign in_done = (state_q == DONE);

  // Unpack the flat requester buses and split the latched operands/sum into lane-sized chunks.
  for (genvar g = 0; g < NREQ; g++) begin : g_req_unpack
    assign req_a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign req_b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk_split
    assign a_chunks[g]                   = a_q[g*LANE_W +: LANE_W];
    assign b_chunks[g]                   = b_q[g*LANE_W +: LANE_W];
    assign sum_flat[g*LANE_W +: LANE_W]  = sum_q[g];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx[IDW-1:0];
      end
    end
  end

  // After a response is taken, the requester just served drops to lowest priority.
  always_comb begin
    next_ptr = id_q + IDW'(1);
    if (id_q == IDW'(NREQ - 1)) begin
      next_ptr = '0;
    end
  end

  // Next-state logic for the scheduler: accept, step through chunks, hold the response.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    chunk_d  = chunk_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d     = req_a_arr[grant_id];
          b_d     = req_b_arr[grant_id];
          id_d    = grant_id;
          carry_d = req_cin[grant_id];
          chunk_d = '0;
          cout_d  = 1'b0;
          for (int c = 0; c < CHUNKS; c++) begin
            sum_d[c] = '0;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d[chunk_q] = lane_s;
        carry_d        = lane_cout;
        if (chunk_q == CW'(CHUNKS - 1)) begin
          chunk_d = '0;
          cout_d  = lane_cout;
          state_d = DONE;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scheduler registers; an async reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      chunk_q  <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      sum_q    <= '{default: '0};
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      chunk_q  <= chunk_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Accept strobe is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && in_idle && grant_found) begin
      req_ready = NREQ'(1) << grant_id;
    end
  end

  // Lane drive: only the current chunk during EXEC, quiet zeros otherwise.
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    lane_cin = 1'b0;
    if (in_exec) begin
      lane_a   = a_chunks[chunk_q];
      lane_b   = b_chunks[chunk_q];
      lane_cin = carry_q;
    end
  end

  // Response fields are presented only while holding a finished result.
  always_comb begin
    rsp_valid = in_done;
    rsp_id    = in_done ? id_q : '0;
    rsp_sum   = in_done ? sum_flat : '0;
    rsp_cout  = in_done & cout_q;
    busy      = in_exec | in_done;
  end

endmodule

// File: tb/tb_fir_add_lane_sched.sv
// Testbench for fir_add_lane_sched: table-driven single ops, hand-written
// corner sequences (backpressure, reset mid-op, round-robin order) and a
// randomized run checked against a transaction-level reference model.
module tb_fir_add_lane_sched;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 12;
  localparam int LANE_W = 3;
  localparam int CHUNKS = WIDTH / LANE_W;
  localparam int IDW    = $clog2(NREQ);

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic [LANE_W-1:0]     lane_a;
  logic [LANE_W-1:0]     lane_b;
  logic                  lane_cin;
  logic [LANE_W-1:0]     lane_s;
  logic                  lane_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  busy;

  logic [WIDTH-1:0]      a_slot [NREQ];
  logic [WIDTH-1:0]      b_slot [NREQ];

  int n_checks;
  int n_errors;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs [8];

  fir_add_lane_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .lane_a    (lane_a),
    .lane_b    (lane_b),
    .lane_cin  (lane_cin),
    .lane_s    (lane_s),
    .lane_cout (lane_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  // External combinational adder lane.
  assign {lane_cout, lane_s} = {1'b0, lane_a} + {1'b0, lane_b} + {{LANE_W{1'b0}}, lane_cin};

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*WIDTH +: WIDTH] = a_slot[g];
    assign req_b[g*WIDTH +: WIDTH] = b_slot[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Randomizes every slot, then places the chosen operands in slot id.
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [IDW-1:0] id,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic rdy);
    for (int i = 0; i < NREQ; i++) begin
      a_slot[IDW'(i)] = WIDTH'($urandom);
      b_slot[IDW'(i)] = WIDTH'($urandom);
    end
    req_cin    = NREQ'($urandom);
    a_slot[id] = a;
    b_slot[id] = b;
    req_cin[id] = cin;
    req_valid  = valid;
    rsp_ready  = rdy;
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({req_ready, lane_a, lane_b, lane_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy});
  endfunction

  // Carry entering chunk k, derived from the plain sum of the lower k chunks.
  function automatic logic carryInto(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input int k);
    int mask;
    int s;
    mask = (1 << (k * LANE_W)) - 1;
    s    = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
    return 1'((s >> (k * LANE_W)) & 1);
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_outputs", allOutputs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated op: accept, four EXEC chunks, one DONE cycle with rsp_ready high.
  task automatic doSingleOp(input vec_t v);
    logic [WIDTH:0] full;
    full = {1'b0, v.a} + {1'b0, v.b} + (WIDTH+1)'(v.cin);
    @(negedge clk);
    applyStimulus(NREQ'(1) << v.id, v.id, v.a, v.b, v.cin, 1'b1);
    #1;
    checkOutput("op_req_ready", 64'(req_ready), 64'(NREQ'(1) << v.id));
    checkOutput("op_idle_busy", 64'(busy), 64'd0);
    for (int k = 0; k < CHUNKS; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus('0, v.id, '0, '0, 1'b0, 1'b1);
      #1;
      checkOutput("exec_lane_a", 64'(lane_a), 64'(LANE_W'(v.a >> (k * LANE_W))));
      checkOutput("exec_lane_b", 64'(lane_b), 64'(LANE_W'(v.b >> (k * LANE_W))));
      checkOutput("exec_lane_cin", 64'(lane_cin), 64'(carryInto(v.a, v.b, v.cin, k)));
      checkOutput("exec_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("exec_busy", 64'(busy), 64'd1);
      checkOutput("exec_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    #1;
    checkOutput("done_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("done_rsp_id", 64'(rsp_id), 64'(v.id));
    checkOutput("done_rsp_sum", 64'(rsp_sum), 64'(v.exp_sum));
    checkOutput("done_rsp_cout", 64'(rsp_cout), 64'(v.exp_cout));
    checkOutput("model_sum", 64'(full), 64'({v.exp_cout, v.exp_sum}));
  endtask

  int             rr_ids [8];
  int             rr_cyc [8];
  int             rr_n;
  int             m_ptr;
  logic           m_pend;
  int             m_cnt;
  int             m_id;
  logic [WIDTH:0] m_full;
  logic [NREQ-1:0] rmask;
  int             m_grant;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_slot[IDW'(i)] = '0;
      b_slot[IDW'(i)] = '0;
    end

    vecs[0] = '{id: 2'd2, a: 12'hFFF, b: 12'h001, cin: 1'b0, exp_sum: 12'h000, exp_cout: 1'b1};
    vecs[1] = '{id: 2'd0, a: 12'h7FF, b: 12'h800, cin: 1'b1, exp_sum: 12'h000, exp_cout: 1'b1};
    vecs[2] = '{id: 2'd1, a: 12'h123, b: 12'h456, cin: 1'b0, exp_sum: 12'h579, exp_cout: 1'b0};
    vecs[3] = '{id: 2'd3, a: 12'h800, b: 12'h800, cin: 1'b0, exp_sum: 12'h000, exp_cout: 1'b1};
    vecs[4] = '{id: 2'd3, a: 12'h000, b: 12'h000, cin: 1'b1, exp_sum: 12'h001, exp_cout: 1'b0};
    vecs[5] = '{id: 2'd3, a: 12'hABC, b: 12'h544, cin: 1'b1, exp_sum: 12'h001, exp_cout: 1'b1};
    vecs[6] = '{id: 2'd0, a: 12'h555, b: 12'h2AA, cin: 1'b0, exp_sum: 12'h7FF, exp_cout: 1'b0};
    vecs[7] = '{id: 2'd1, a: 12'h0FF, b: 12'hF01, cin: 1'b0, exp_sum: 12'h000, exp_cout: 1'b1};

    doReset();

    // Table vectors; entries 3..5 re-serve requester 3 back to back (wrap search).
    for (int i = 0; i < 8; i++) begin
      doSingleOp(vecs[i]);
    end

    // Backpressure: pointer now at 2, only requester 0 valid at first.
    @(negedge clk);
    applyStimulus(4'b0001, 2'd0, 12'h123, 12'h010, 1'b0, 1'b0);
    #1;
    checkOutput("bp_first_grant", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b1111;
    for (int k = 1; k < CHUNKS; k++) begin
      @(negedge clk);
    end
    #1;
    checkOutput("bp_exec_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_rsp_sum", 64'(rsp_sum), 64'h133);
      checkOutput("bp_rsp_id", 64'(rsp_id), 64'd0);
      checkOutput("bp_rsp_cout", 64'(rsp_cout), 64'd0);
      checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_valid", 64'(rsp_valid), 64'd1);
    checkOutput("bp_release_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("bp_next_grant", 64'(req_ready), 64'h2);
    req_valid = '0;

    // Reset mid-op: serve requester 2 (pointer -> 3), then abort a second op in chunk 2.
    doSingleOp('{id: 2'd2, a: 12'h00F, b: 12'h001, cin: 1'b0, exp_sum: 12'h010, exp_cout: 1'b0});
    @(negedge clk);
    applyStimulus(4'b0100, 2'd2, 12'h5A5, 12'h0F0, 1'b1, 1'b1);
    #1;
    checkOutput("rst_grant", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_chunk2_lane_a", 64'(lane_a), 64'(LANE_W'(12'h5A5 >> (2 * LANE_W))));
    rst_n     = 1'b0;
    req_valid = 4'b1010;
    #1;
    checkOutput("rst_outputs_now", allOutputs(), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_outputs_held", allOutputs(), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_grant_from_zero", 64'(req_ready), 64'h2);
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_no_response", 64'(rsp_valid), 64'd0);
    end

    // Round-robin with all requesters valid and rsp_ready tied high.
    doReset();
    @(negedge clk);
    applyStimulus(4'b1111, 2'd0, 12'h001, 12'h001, 1'b0, 1'b1);
    rr_n = 0;
    for (int cyc = 0; cyc < 28; cyc++) begin
      #1;
      if (req_ready != '0) begin
        if (rr_n < 8) begin
          rr_cyc[rr_n] = cyc;
          rr_ids[rr_n] = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (req_ready[IDW'(i)]) rr_ids[rr_n] = i;
          end
        end
        rr_n++;
      end
      @(negedge clk);
    end
    checkOutput("rr_grant_count", 64'(rr_n), 64'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < rr_n) begin
        checkOutput("rr_grant_id", 64'(rr_ids[j]), 64'(j % NREQ));
        checkOutput("rr_grant_cycle", 64'(rr_cyc[j]), 64'(j * (CHUNKS + 2)));
      end
    end

    // Randomized traffic against a transaction-level model.
    doReset();
    m_ptr  = 0;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_id   = 0;
    m_full = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rmask = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      applyStimulus(rmask, IDW'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom), ($urandom_range(0, 3) != 0));
      #1;
      m_grant = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (m_grant < 0 && ((rmask >> ((m_ptr + k) % NREQ)) & 1) != 0) begin
          m_grant = (m_ptr + k) % NREQ;
        end
      end
      if (!m_pend) begin
        checkOutput("rnd_req_ready", 64'(req_ready), (m_grant >= 0) ? (64'd1 << m_grant) : 64'd0);
      end else begin
        checkOutput("rnd_req_ready_busy", 64'(req_ready), 64'd0);
      end
      checkOutput("rnd_busy", 64'(busy), 64'(m_pend));
      checkOutput("rnd_rsp_valid", 64'(rsp_valid), 64'(m_pend && m_cnt == CHUNKS));
      if (m_pend && m_cnt == CHUNKS) begin
        checkOutput("rnd_rsp", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({IDW'(m_id), m_full}));
      end
      if (!m_pend) begin
        if (m_grant >= 0) begin
          m_pend = 1'b1;
          m_cnt  = 0;
          m_id   = m_grant;
          m_full = {1'b0, a_slot[IDW'(m_grant)]} + {1'b0, b_slot[IDW'(m_grant)]}
                 + (WIDTH+1)'(req_cin[IDW'(m_grant)]);
        end
      end else if (m_cnt == CHUNKS) begin
        if (rsp_ready) begin
          m_pend = 1'b0;
          m_ptr  = (m_id + 1) % NREQ;
        end
      end else begin
        m_cnt++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
